pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Reset/lock sequencer that sits directly on both sides of the general-purpose PLL wrapper (100 MHz refclk in, 60 MHz outclk_0 out). It runs on the free-running reference clock and drives the PLL's active-high rst. It also consumes the PLL's asynchronous locked output. It releases a clean system reset only after lock has been stable for a qualified time, and re-sequences the PLL on lock loss or lock timeout.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT_CYCLES, 100000, cycles to wait for lock before retrying (1 ms at 100 MHz)
STABLE_CYCLES, 1024, cycles locked must stay high continuously before release
SYNC_STAGES, 2, flops in the locked synchronizer (>=2)
MAX_RETRIES, 0, consecutive timeouts before FAIL; 0 = retry forever

Ports:
refclk  input  1  reference clock, same net as the PLL refclk
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked, asynchronous to refclk
pll_rst  output  1  active-high reset to PLL rst
sys_rst_n  output  1  active-low system reset request; downstream domains synchronize it locally
ready  output  1  high while in RUN
fail  output  1  high in FAIL (retries exhausted)
lock_loss_cnt  output  8  count of lock losses seen in RUN (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=PLL_RST, counter=0, retry_cnt=0, sync chain=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0, lock_loss_cnt=0.
- pll_locked passes through SYNC_STAGES flops and becomes locked_s. Nothing else samples pll_locked.
- Moore outputs decode from the registered state only:
  - pll_rst=1 in PLL_RST and FAIL.
  - sys_rst_n=1 and ready=1 only in RUN.
  - fail=1 only in FAIL.
- One shared counter, width $clog2 of the largest cycle parameter. It clears on every state change.
- PLL_RST: count up. At cnt==PLL_RST_CYCLES-1 go to WAIT_LOCK. pll_rst is high for exactly PLL_RST_CYCLES cycles after rst_n release.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Else at cnt==LOCK_TIMEOUT_CYCLES-1, retry_cnt++. If MAX_RETRIES!=0 and the new retry_cnt==MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
  - If locked_s and the timeout occur in the same cycle, lock wins.
- STABLE:
  - If locked_s=0, go back to WAIT_LOCK with a fresh timeout and no retry increment.
  - Else at cnt==STABLE_CYCLES-1, go to RUN.
  - Latency: locked_s rising at cycle t (state WAIT_LOCK) gives sys_rst_n=1 at cycle t+1+STABLE_CYCLES.
- RUN: retry_cnt clears on entry. If locked_s=0, go to PLL_RST. sys_rst_n falls and pll_rst rises on the next cycle.
- FAIL: terminal. pll_rst is held high; leaves only via rst_n.
- retry_cnt saturates and never wraps.
- A glitch on pll_locked shorter than one refclk may or may not be seen. Either outcome must follow the rules above.
- Reset mid-operation returns to reset values immediately, whatever the state.

Optional Feature:
PLL_LOCK_LOSS_CNT_EN:
- Defined: lock_loss_cnt increments by 1 on each RUN->PLL_RST transition and saturates at 255. It clears only on rst_n.
- Undefined: lock_loss_cnt is tied to 8'd0 and no counter flops are built.
- The port exists in both builds.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL (3-bit);
  - LOSS_CNT_W=8;
  - a helper function giving the max cycle parameter for counter width.
- Sub-module bit_sync (parameter STAGES, async active-low reset to 0) holds the locked synchronizer. It is reusable for other CDC single bits.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, SYNC_STAGES=2, MAX_RETRIES=3.
1. Normal bring-up: release rst_n, pll_locked rises 10 cycles later -> pll_rst high exactly 4 cycles; sys_rst_n=1 and ready=1 exactly 2+1+8 cycles after pll_locked rises.
2. Lock bounce: in STABLE, drop pll_locked for 3 cycles at stable cnt=5 -> return to WAIT_LOCK, no retry increment; release occurs 8 cycles after the re-qualified lock.
3. Timeout retry: hold pll_locked=0 -> three 4-cycle pll_rst pulses separated by 20-cycle waits, then fail=1 and pll_rst stays 1 until rst_n.
4. Lock loss in RUN: drop pll_locked -> sys_rst_n=0 and pll_rst=1 three cycles later; lock_loss_cnt=1 with PLL_LOCK_LOSS_CNT_EN, 0 without; relock releases again with retry_cnt cleared.
5. Async reset mid-STABLE: assert rst_n=0 with no clock edge -> pll_rst=1, sys_rst_n=0, ready=0 immediately; lock_loss_cnt=0.
6. Saturation: with the macro defined, force 260 RUN lock losses -> lock_loss_cnt holds 255.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max_cycles(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold values 0..m-1, never less than one bit.
    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running refclk.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int SYNC_STAGES         = 2,
    parameter int MAX_RETRIES         = 0
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_W   = cnt_width(max_cycles(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES));
    localparam int RETRY_W = cnt_width(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT   = {RETRY_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

    seq_state_e         state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [RETRY_W-1:0] retry_r, retry_s;
    logic               locked_s;
    logic               pll_rst_r, sys_rst_n_r, ready_r, fail_r;

    bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_s = state_r;
        retry_s = retry_r;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == RST_LAST) state_s = WAIT_LOCK;
                else                   state_s = PLL_RST;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout in the same cycle.
                if (locked_s) begin
                    state_s = STABLE;
                end else if (cnt_r == TO_LAST) begin
                    retry_s = (retry_r == RETRY_SAT) ? retry_r : retry_r + RETRY_ONE;
                    if ((MAX_RETRIES != 0) && (retry_s == RETRY_LIMIT)) state_s = FAIL;
                    else                                                state_s = PLL_RST;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_s = WAIT_LOCK;
                end else if (cnt_r == STB_LAST) begin
                    state_s = RUN;
                    retry_s = {RETRY_W{1'b0}};
                end else begin
                    state_s = STABLE;
                end
            end
            RUN: begin
                if (!locked_s) state_s = PLL_RST;
                else           state_s = RUN;
            end
            FAIL: begin
                state_s = FAIL;
            end
            default: begin
                state_s = PLL_RST;
            end
        endcase

        if (state_s != state_r)                        cnt_s = {CNT_W{1'b0}};
        else if ((state_r == RUN) || (state_r == FAIL)) cnt_s = cnt_r;
        else                                            cnt_s = cnt_r + CNT_ONE;
    end

    // State, counter and outputs; outputs are decoded from the next state so they track state_r exactly.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= PLL_RST;
            cnt_r       <= {CNT_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            retry_r     <= retry_s;
            pll_rst_r   <= (state_s == PLL_RST) || (state_s == FAIL);
            sys_rst_n_r <= (state_s == RUN);
            ready_r     <= (state_s == RUN);
            fail_r      <= (state_s == FAIL);
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign ready     = ready_r;
    assign fail      = fail_r;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_r;

    // Saturating count of lock losses while running.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= {LOSS_CNT_W{1'b0}};
        end else if ((state_r == RUN) && (state_s == PLL_RST) && (loss_cnt_r != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_cnt = loss_cnt_r;
`else
    assign lock_loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output transitions; a monitor checks them.
module tb_pll_reset_sequencer;

    localparam logic [3:0] V_RST  = 4'b1000;  // {pll_rst, sys_rst_n, ready, fail}
    localparam logic [3:0] V_WAIT = 4'b0000;
    localparam logic [3:0] V_RUN  = 4'b0110;
    localparam logic [3:0] V_FAIL = 4'b1001;
`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [7:0] lock_loss_cnt;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        string      name;
    } ev_t;

    ev_t        sb_q[$];
    ev_t        ev;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev = 4'b1000;
    logic [3:0] cur;
    logic [3:0] exp_vec = 4'b1000;
    int         exp_loss;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .STABLE_CYCLES       (8),
        .SYNC_STAGES         (2),
        .MAX_RETRIES         (3)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    // Monitor: every change of the output vector must match the next queued event.
    always @(negedge refclk) begin
        cur = {pll_rst, sys_rst_n, ready, fail};
        if (cur !== prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %b at cycle %0d, expected no change", cur, cyc);
            end else begin
                ev = sb_q.pop_front();
                if ((ev.cyc != cyc) || (ev.vec !== cur)) begin
                    errors++;
                    $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                             ev.name, cur, cyc, ev.vec, ev.cyc);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input int c, input logic [3:0] v, input string name);
        ev_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = name;
        sb_q.push_back(e);
        exp_vec = v;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // Assert rst_n between edges and check that outputs react with no clock.
    task automatic do_reset(input string name);
        @(negedge refclk);
        #2;
        if (exp_vec != V_RST) push(cyc + 1, V_RST, name);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        #1;
        check({name, "_pll_rst"}, {7'd0, pll_rst}, 8'd1);
        check({name, "_sys_rst_n"}, {7'd0, sys_rst_n}, 8'd0);
        check({name, "_ready"}, {7'd0, ready}, 8'd0);
        check({name, "_fail"}, {7'd0, fail}, 8'd0);
        check({name, "_loss"}, lock_loss_cnt, 8'd0);
        repeat (3) @(negedge refclk);
    endtask

    task automatic do_release(output int c0);
        @(negedge refclk);
        rst_n = 1'b1;
        c0 = cyc;
        push(c0 + 4, V_WAIT, "pll_rst_pulse_end");
    endtask

    initial begin
        int c0, p, q, r, s;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("reset_pll_rst", {7'd0, pll_rst}, 8'd1);
        check("reset_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        check("reset_ready", {7'd0, ready}, 8'd0);
        check("reset_fail", {7'd0, fail}, 8'd0);
        check("reset_loss", lock_loss_cnt, 8'd0);

        // Bring-up, lock loss in RUN, one timeout, relock, then lock loss held to FAIL.
        do_release(c0);
        wait_to(c0 + 10);
        pll_locked = 1'b1;
        push(c0 + 21, V_RUN, "bringup_release");
        wait_to(c0 + 25);
        r = cyc;
        pll_locked = 1'b0;
        push(r + 3,  V_RST,  "run_loss_pll_rst");
        push(r + 7,  V_WAIT, "run_loss_wait");
        push(r + 27, V_RST,  "timeout_retry1");
        push(r + 31, V_WAIT, "timeout_retry1_wait");
        push(r + 44, V_RUN,  "relock_release");
        wait_to(r + 4);
        check("loss_cnt_first", lock_loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
        wait_to(r + 33);
        pll_locked = 1'b1;
        wait_to(r + 48);
        s = cyc;
        pll_locked = 1'b0;
        push(s + 3,  V_RST,  "loss2_pll_rst");
        push(s + 7,  V_WAIT, "loss2_wait");
        push(s + 27, V_RST,  "cleared_retry1");
        push(s + 31, V_WAIT, "cleared_retry1_wait");
        push(s + 51, V_RST,  "cleared_retry2");
        push(s + 55, V_WAIT, "cleared_retry2_wait");
        push(s + 75, V_FAIL, "cleared_retry3_fail");
        wait_to(s + 90);
        check("loss_cnt_second", lock_loss_cnt, LOSS_EN ? 8'd2 : 8'd0);
        check("fail_held", {7'd0, fail}, 8'd1);
        do_reset("rst_from_fail");

        // Async reset in STABLE after one lock loss.
        do_release(c0);
        wait_to(c0 + 10);
        pll_locked = 1'b1;
        push(c0 + 21, V_RUN, "t5_release");
        wait_to(c0 + 24);
        r = cyc;
        pll_locked = 1'b0;
        push(r + 3, V_RST,  "t5_loss");
        push(r + 7, V_WAIT, "t5_wait");
        wait_to(r + 8);
        pll_locked = 1'b1;
        wait_to(r + 14);
        check("t5_loss_cnt", lock_loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
        do_reset("t5_async_rst_stable");

        // Lock bounce in STABLE at cnt=5.
        do_release(c0);
        p = c0 + 10;
        wait_to(p);
        pll_locked = 1'b1;
        q = p + 6;
        wait_to(q);
        pll_locked = 1'b0;
        wait_to(q + 3);
        pll_locked = 1'b1;
        push(q + 14, V_RUN, "bounce_release");
        wait_to(q + 20);
        do_reset("rst_after_bounce");

        // Pure timeouts from reset: three pulses then FAIL.
        do_release(c0);
        push(c0 + 24, V_RST,  "to_pulse2");
        push(c0 + 28, V_WAIT, "to_wait2");
        push(c0 + 48, V_RST,  "to_pulse3");
        push(c0 + 52, V_WAIT, "to_wait3");
        push(c0 + 72, V_FAIL, "to_fail");
        wait_to(c0 + 110);
        check("to_fail_hold", {7'd0, fail}, 8'd1);
        check("to_pll_rst_hold", {7'd0, pll_rst}, 8'd1);
        do_reset("rst_after_timeouts");

`ifdef PLL_LOCK_LOSS_CNT_EN
        // Saturation of the lock-loss counter.
        do_release(c0);
        wait_to(c0 + 10);
        pll_locked = 1'b1;
        push(c0 + 21, V_RUN, "sat_release");
        wait_to(c0 + 24);
        exp_loss = 0;
        for (int i = 0; i < 260; i++) begin
            r = cyc;
            pll_locked = 1'b0;
            push(r + 3,  V_RST,  "sat_loss");
            push(r + 7,  V_WAIT, "sat_wait");
            push(r + 19, V_RUN,  "sat_run");
            wait_to(r + 8);
            pll_locked = 1'b1;
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            wait_to(r + 22);
            if ((i < 2) || (i > 252)) check("sat_loss_cnt", lock_loss_cnt, 8'(exp_loss));
        end
        do_reset("rst_after_sat");
`endif

        repeat (5) @(negedge refclk);
        while (sb_q.size() != 0) begin
            ev = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no transition, expected %b at cycle %0d", ev.name, ev.vec, ev.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
